// File: rtl/fp_prep_pipe.sv
// Floating-point front end: unpacks operands, sorts by magnitude, derives shifts/flags/exponents, multiplies significands.
// Latency: MUL_STAGES cycles (input sampled at edge 0 is visible after edge MUL_STAGES-1); one instruction per cycle.
// Backpressure: none; the pipeline always advances, and rollback clears valids of the matching thread.
module fp_prep_pipe #(
    parameter int LANES      = 16,
    parameter int EXP_WIDTH  = 8,
    parameter int SIG_WIDTH  = 23,
    parameter int MUL_STAGES = 2,
    parameter int TID_WIDTH  = 2
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            rollback_en,
    input  logic [TID_WIDTH-1:0]                            rollback_tid,
    input  logic                                            in_valid,
    input  logic [1:0]                                      in_op,
    input  logic [TID_WIDTH-1:0]                            in_tid,
    input  logic [LANES-1:0]                                in_mask,
    input  logic [LANES*(1+EXP_WIDTH+SIG_WIDTH)-1:0]        in_a,
    input  logic [LANES*(1+EXP_WIDTH+SIG_WIDTH)-1:0]        in_b,
    output logic                                            out_valid,
    output logic [1:0]                                      out_op,
    output logic [TID_WIDTH-1:0]                            out_tid,
    output logic [LANES-1:0]                                out_mask,
    output logic [LANES*(SIG_WIDTH+1)-1:0]                  out_sig_le,
    output logic [LANES*(SIG_WIDTH+1)-1:0]                  out_sig_se,
    output logic [LANES*$clog2(SIG_WIDTH+5)-1:0]            out_align_shift,
    output logic [LANES*EXP_WIDTH-1:0]                      out_add_exp,
    output logic [LANES-1:0]                                out_logical_sub,
    output logic [LANES-1:0]                                out_add_sign,
    output logic [LANES*2*(SIG_WIDTH+1)-1:0]                out_product,
    output logic [LANES*EXP_WIDTH-1:0]                      out_mul_exp,
    output logic [LANES-1:0]                                out_mul_sign,
    output logic [LANES-1:0]                                out_mul_underflow,
    output logic [LANES-1:0]                                out_is_nan,
    output logic [LANES-1:0]                                out_is_inf
);

    localparam int W    = 1 + EXP_WIDTH + SIG_WIDTH;
    localparam int F    = SIG_WIDTH + 1;
    localparam int P    = 2 * F;
    localparam int SH   = $clog2(SIG_WIDTH + 5);
    localparam int NS   = MUL_STAGES;
    localparam int SW   = (F + NS - 1) / NS;        // multiplier slice width
    localparam int PB   = NS * SW;                  // Fb padded to whole slices
    localparam int EW2  = EXP_WIDTH + 2;            // signed exponent headroom
    localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int EMAX = (1 << EXP_WIDTH) - 1;
    // Per-lane sideband carried alongside the multiplier
    localparam int LW   = 2 * F + SH + 2 * EXP_WIDTH + 6;

    // Stage registers, index 0 is stage 1
    logic                   vld_q  [NS];
    logic [1:0]             op_q   [NS];
    logic [TID_WIDTH-1:0]   tid_q  [NS];
    logic [LANES-1:0]       mask_q [NS];
    logic [LANES*LW-1:0]    side_q [NS];
    logic [LANES*F-1:0]     fa_q   [NS];
    logic [LANES*F-1:0]     fb_q   [NS];
    logic [LANES*P-1:0]     acc_q  [NS];

    logic [LANES*LW-1:0]    side_d;
    logic [LANES*F-1:0]     fa_d;
    logic [LANES*F-1:0]     fb_d;
    logic [LANES*P-1:0]     acc_d  [NS];

    logic is_sub;
    logic is_mul;

    assign is_sub = (in_op != 2'b00);
    assign is_mul = (in_op == 2'b10);

    // Fa times slice k of Fb, placed at its bit weight
    function automatic logic [P-1:0] part_prod(input logic [F-1:0] a, input logic [F-1:0] b, input int k);
        logic [PB-1:0] b_pad;
        logic [SW-1:0] slice;
        b_pad = PB'(b);
        slice = b_pad[k*SW +: SW];
        return (P'(a) * P'(slice)) << (k * SW);
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic                 sa, sb;
        logic [EXP_WIDTH-1:0] ea, eb;
        logic [SIG_WIDTH-1:0] ma, mb;
        logic [F-1:0]         fa, fb;
        logic                 inf_a, inf_b, nan_a, nan_b, zero_a, zero_b;
        logic                 a_big, lsub, asign;
        logic [EXP_WIDTH-1:0] ediff, aexp, mexp;
        logic [SH-1:0]        shift;
        logic [F-1:0]         sig_le, sig_se;
        logic [EW2-1:0]       mexp_full;
        logic                 mul_uf_raw, mul_ovf;
        logic                 nan, inf, uf;

        assign {sa, ea, ma} = in_a[l*W +: W];
        assign {sb, eb, mb} = in_b[l*W +: W];
        assign fa = {ea != '0, ma};
        assign fb = {eb != '0, mb};

        // Classify operands, order by magnitude and derive add/multiply controls and flags
        always_comb begin
            inf_a  = (ea == '1) && (ma == '0);
            inf_b  = (eb == '1) && (mb == '0);
            nan_a  = (ea == '1) && (ma != '0);
            nan_b  = (eb == '1) && (mb != '0);
            zero_a = (ea == '0) && (ma == '0);
            zero_b = (eb == '0) && (mb == '0);
            lsub   = sa ^ sb ^ is_sub;
            a_big  = (ea > eb) || ((ea == eb) && (fa >= fb));
            if (a_big) begin
                sig_le = fa;
                sig_se = fb;
                aexp   = ea;
                asign  = sa;
                ediff  = ea - eb;
            end else begin
                sig_le = fb;
                sig_se = fa;
                aexp   = eb;
                asign  = sb ^ is_sub;
                ediff  = eb - ea;
            end
            if (int'(ediff) > SIG_WIDTH + 4) shift = SH'(SIG_WIDTH + 4);
            else                             shift = SH'(ediff);
            mexp_full  = EW2'(ea) + EW2'(eb) - EW2'(BIAS);
            mul_uf_raw = mexp_full[EW2-1] || (mexp_full == '0);
            mul_ovf    = !mexp_full[EW2-1] && (mexp_full >= EW2'(EMAX));
            mexp       = mul_uf_raw ? '0 : mexp_full[EXP_WIDTH-1:0];
            if (is_mul) nan = nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a);
            else        nan = nan_a || nan_b || (inf_a && inf_b && lsub);
            inf = !nan && (inf_a || inf_b || (is_mul && mul_ovf));
            uf  = mul_uf_raw && !nan && !inf;
        end

        assign side_d[l*LW +: LW] = {sig_le, sig_se, shift, aexp, mexp, lsub, asign, sa ^ sb, uf, nan, inf};
        assign fa_d[l*F +: F]     = fa;
        assign fb_d[l*F +: F]     = fb;

        assign {out_sig_le[l*F +: F], out_sig_se[l*F +: F], out_align_shift[l*SH +: SH],
                out_add_exp[l*EXP_WIDTH +: EXP_WIDTH], out_mul_exp[l*EXP_WIDTH +: EXP_WIDTH],
                out_logical_sub[l], out_add_sign[l], out_mul_sign[l], out_mul_underflow[l],
                out_is_nan[l], out_is_inf[l]} = side_q[NS-1][l*LW +: LW];
    end

    // Accumulate one Fb slice per stage; stage 1 starts from zero
    always_comb begin
        for (int k = 0; k < NS; k++) acc_d[k] = '0;
        for (int l = 0; l < LANES; l++) begin
            acc_d[0][l*P +: P] = part_prod(fa_d[l*F +: F], fb_d[l*F +: F], 0);
            for (int k = 1; k < NS; k++) begin
                acc_d[k][l*P +: P] = acc_q[k-1][l*P +: P] + part_prod(fa_q[k-1][l*F +: F], fb_q[k-1][l*F +: F], k);
            end
        end
    end

    // Advance the pipeline, dropping any entry of the rolled-back thread as it moves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NS; k++) begin
                vld_q[k]  <= 1'b0;
                op_q[k]   <= '0;
                tid_q[k]  <= '0;
                mask_q[k] <= '0;
                side_q[k] <= '0;
                fa_q[k]   <= '0;
                fb_q[k]   <= '0;
                acc_q[k]  <= '0;
            end
        end else begin
            vld_q[0]  <= in_valid && !(rollback_en && (in_tid == rollback_tid));
            op_q[0]   <= in_op;
            tid_q[0]  <= in_tid;
            mask_q[0] <= in_mask;
            side_q[0] <= side_d;
            fa_q[0]   <= fa_d;
            fb_q[0]   <= fb_d;
            acc_q[0]  <= acc_d[0];
            for (int k = 1; k < NS; k++) begin
                vld_q[k]  <= vld_q[k-1] && !(rollback_en && (tid_q[k-1] == rollback_tid));
                op_q[k]   <= op_q[k-1];
                tid_q[k]  <= tid_q[k-1];
                mask_q[k] <= mask_q[k-1];
                side_q[k] <= side_q[k-1];
                fa_q[k]   <= fa_q[k-1];
                fb_q[k]   <= fb_q[k-1];
                acc_q[k]  <= acc_d[k];
            end
        end
    end

    assign out_valid   = vld_q[NS-1];
    assign out_op      = op_q[NS-1];
    assign out_tid     = tid_q[NS-1];
    assign out_mask    = mask_q[NS-1];
    assign out_product = acc_q[NS-1];

endmodule
